// File: rtl/sqrt_arb_pkg.sv
// rtl/sqrt_arb_pkg.sv - shared state encoding and parameter defaults for the sqrt arbiter
package sqrt_arb_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_rr_pick.sv
// rtl/sqrt_rr_pick.sv - combinational round-robin picker, searches from last_id+1 upward with wrap
module sqrt_rr_pick
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_id,
  output logic [IDW-1:0]  grant_id,
  output logic            valid
);

  logic [IDW-1:0] idx;

  // first active request after last_id wins; last_id itself is checked last
  always_comb begin
    grant_id = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = IDW'((int'(last_id) + off) % NREQ);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one external squareroot unit among NREQ requesters
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     a_bus,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic [WIDTH-1:0]          result,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      sq_en,
  output logic                      sq_rst,
  output logic [WIDTH-1:0]          sq_a,
  input  logic                      sq_rdy,
  input  logic [WIDTH-1:0]          sq_sqrt
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT);

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] last_id_q;
  logic [IDW-1:0] pick_id;
  logic           pick_valid;
  logic [CW-1:0]  cnt_q;
  logic           err_q;
  logic           run_timeout;

  assign run_timeout = (cnt_q == CW'(TIMEOUT - 1));

  sqrt_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req      (req),
    .last_id  (last_id_q),
    .grant_id (pick_id),
    .valid    (pick_valid)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // next-state: grant -> one clear cycle -> run until rdy or timeout -> one done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN:     if (sq_rdy || run_timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath: operand/index latch at grant, run counter, result capture, round-robin pointer
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_id  <= '0;
      sq_a      <= '0;
      result    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      last_id_q <= IDW'(NREQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_id <= pick_id;
            sq_a     <= a_bus[int'(pick_id)*WIDTH +: WIDTH];
          end
        end
        CLEAR: begin
          cnt_q <= '0;
          err_q <= 1'b0;
        end
        RUN: begin
          // a ready sample beats a same-cycle timeout
          if (sq_rdy) begin
            result <= sq_sqrt;
            err_q  <= 1'b0;
          end else if (run_timeout) begin
            result <= '0;
            err_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE:    last_id_q <= grant_id;
        default: ;
      endcase
    end
  end

  // outputs decoded from state; done is one-hot on the served requester
  always_comb begin
    done   = '0;
    busy   = (state_q != IDLE);
    sq_en  = (state_q == RUN);
    sq_rst = !rst || (state_q == CLEAR);
    err    = (state_q == DONE) && err_q;
    if (state_q == DONE) done[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - self-checking bench for sqrt_arbiter with a latency-programmable squareroot model
module tb_sqrt_arbiter;

  localparam int WIDTH   = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [WIDTH-1:0]      result;
  logic [1:0]            grant_id;
  logic                  busy;
  logic                  sq_en;
  logic                  sq_rst;
  logic [WIDTH-1:0]      sq_a;
  logic                  sq_rdy;
  logic [WIDTH-1:0]      sq_sqrt;

  sqrt_arbiter #(
    .WIDTH   (WIDTH),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_bus    (a_bus),
    .done     (done),
    .err      (err),
    .result   (result),
    .grant_id (grant_id),
    .busy     (busy),
    .sq_en    (sq_en),
    .sq_rst   (sq_rst),
    .sq_a     (sq_a),
    .sq_rdy   (sq_rdy),
    .sq_sqrt  (sq_sqrt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
    longint r;
    longint av;
    if (a == 32'h41800000) return 32'h40800000;
    av = longint'({32'b0, a});
    r  = 0;
    while ((r + 1) * (r + 1) <= av) r++;
    return r[31:0];
  endfunction

  int lat   = 1000;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (sq_rst && !sq_en) m_cnt <= 0;
    else if (sq_en)       m_cnt <= m_cnt + 1;
  end

  assign sq_rdy  = sq_en && (m_cnt >= lat);
  assign sq_sqrt = sq_rdy ? ref_sqrt(sq_a) : 32'hDEADBEEF;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
    int          since;
  } exp_t;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    int          lat;
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
    int          since;
  } vec_t;

  exp_t sb[$];
  vec_t vt[5];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   since = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (busy && !busy_prev) since = 0;
    else                    since = since + 1;
    busy_prev = busy;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [31:0] res, input logic e, input int s);
    exp_t x;
    x.id = id; x.res = res; x.err = e; x.since = s;
    sb.push_back(x);
  endtask

  task automatic set_op(input int i, input logic [31:0] v);
    a_bus[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic wait_done(input bit drop);
    exp_t e;
    int   n;
    n = 0;
    while (done == '0 && n < 300) begin
      tick();
      n++;
    end
    if (done == '0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one", n);
      if (sb.size() > 0) void'(sb.pop_front());
      req = '0;
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL unexpected_done: got done=%b, expected none", done);
      req = '0;
      return;
    end
    e = sb.pop_front();
    chk("done_vec", 32'(done), 32'(4'b0001 << e.id));
    chk("grant_id", 32'(grant_id), 32'(e.id));
    chk("result", result, e.res);
    chk("err", 32'(err), 32'(e.err));
    chk("latency", since, e.since);
    if (drop) req = '0;
    tick();
    chk("done_pulse", 32'(done), 32'h0);
    chk("err_pulse", 32'(err), 32'h0);
    chk("idle_gap", 32'(busy), 32'h0);
    chk("result_held", result, e.res);
  endtask

  task automatic fill_bg();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'h0001_0000 * (i + 1) + 7);
  endtask

  initial begin
    vt[0] = '{req: 4'b0001, a: 32'h41800000, lat: 5,  id: 2'd0, res: 32'h40800000, err: 1'b0, since: 7};
    vt[1] = '{req: 4'b0010, a: 32'd144,      lat: 0,  id: 2'd1, res: 32'd12,       err: 1'b0, since: 2};
    vt[2] = '{req: 4'b0100, a: 32'd1000000,  lat: 63, id: 2'd2, res: 32'd1000,     err: 1'b0, since: 65};
    vt[3] = '{req: 4'b1000, a: 32'd99,       lat: 64, id: 2'd3, res: 32'd0,        err: 1'b1, since: 65};
    vt[4] = '{req: 4'b0010, a: 32'd50,       lat: 2,  id: 2'd1, res: 32'd7,        err: 1'b0, since: 4};

    rst   = 1'b0;
    req   = '0;
    a_bus = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_sq_en", 32'(sq_en), 32'h0);
    chk("rst_sq_a", sq_a, 32'h0);
    chk("rst_sq_rst", 32'(sq_rst), 32'h1);
    rst = 1'b1;
    tick();
    chk("idle_sq_rst", 32'(sq_rst), 32'h0);
    chk("idle_sq_en", 32'(sq_en), 32'h0);

    // contention: all four held, order 0,1,2,3,0
    lat = 1;
    for (int i = 0; i < NREQ; i++) set_op(i, (i + 2) * (i + 2));
    push_exp(2'd0, 32'd2, 1'b0, 3);
    push_exp(2'd1, 32'd3, 1'b0, 3);
    push_exp(2'd2, 32'd4, 1'b0, 3);
    push_exp(2'd3, 32'd5, 1'b0, 3);
    push_exp(2'd0, 32'd2, 1'b0, 3);
    @(negedge clk);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done(k == 4);

    // single-request table, including rdy/timeout tie and pure timeout
    for (int r = 0; r < 5; r++) begin
      lat = vt[r].lat;
      fill_bg();
      set_op(int'(vt[r].id), vt[r].a);
      @(negedge clk);
      req = vt[r].req;
      push_exp(vt[r].id, vt[r].res, vt[r].err, vt[r].since);
      wait_done(1'b1);
    end

    // fairness: last served was 1, so 3 goes before 0
    lat = 3;
    for (int i = 0; i < NREQ; i++) set_op(i, (i + 2) * (i + 2));
    push_exp(2'd3, 32'd5, 1'b0, 5);
    push_exp(2'd0, 32'd2, 1'b0, 5);
    @(negedge clk);
    req = 4'b1001;
    wait_done(1'b0);
    wait_done(1'b1);

    // request drop and operand change mid-run
    lat = 10;
    fill_bg();
    set_op(1, 32'd144);
    @(negedge clk);
    req = 4'b0010;
    push_exp(2'd1, 32'd12, 1'b0, 12);
    repeat (5) tick();
    req = '0;
    set_op(1, 32'd400);
    tick();
    chk("sq_a_hold", sq_a, 32'd144);
    chk("run_en", 32'(sq_en), 32'h1);
    wait_done(1'b1);

    // reset in the third run cycle
    lat = 1000;
    set_op(3, 32'd81);
    @(negedge clk);
    req = 4'b1000;
    repeat (4) tick();
    chk("pre_rst_run", 32'(sq_en), 32'h1);
    rst = 1'b0;
    req = '0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'h0);
    chk("mid_rst_sq_en", 32'(sq_en), 32'h0);
    chk("mid_rst_sq_a", sq_a, 32'h0);
    chk("mid_rst_sq_rst", 32'(sq_rst), 32'h1);
    rst = 1'b1;
    tick();
    lat = 2;
    set_op(2, 32'd36);
    @(negedge clk);
    req = 4'b0100;
    push_exp(2'd2, 32'd6, 1'b0, 4);
    wait_done(1'b1);

    chk("sb_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand/result width; NREQ, default 4, requester count; TIMEOUT, default 64, maximum RUN cycles before abort.
REQ-002 Port: clk  input  1  single clock; all logic on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  NREQ  per-requester request level, held until that requester's done.
REQ-005 Port: a_bus  input  NREQ*WIDTH  operands, with requester i in bits [i*WIDTH +: WIDTH].
REQ-006 Port: done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-007 Port: err  output  1  one-cycle timeout pulse, coincident with done.
REQ-008 Port: result  output  WIDTH  sqrt result, valid while done is high, held until the next done.
REQ-009 Port: grant_id  output  clog2(NREQ)  index of the requester being served.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: sq_en  output  1  EN to the shared squareroot unit.
REQ-012 Port: sq_rst  output  1  rst to the shared unit, active-high, honoured only while sq_en=0.
REQ-013 Port: sq_a  output  WIDTH  latched operand to the shared unit.
REQ-014 Port: sq_rdy  input  1  rdy from the shared unit.
REQ-015 Port: sq_sqrt  input  WIDTH  sqrt from the shared unit, valid only while sq_rdy=1.

Function
REQ-016 The FSM SHALL have four states: IDLE, CLEAR, RUN, DONE.
REQ-017 In IDLE with req!=0, the arbiter SHALL grant round-robin, searching from last_id+1 upward with wrap, latch the winner's operand into sq_a and its index into grant_id, and go to CLEAR.
REQ-018 In IDLE with req==0, the FSM SHALL stay in IDLE with sq_en=0 and sq_rst=0.
REQ-019 CLEAR SHALL last exactly one cycle with sq_en=0 and sq_rst=1, then go to RUN.
REQ-020 RUN SHALL drive sq_en=1 and sq_rst=0, hold sq_a stable, and increment an internal cycle counter from 0.
REQ-021 In RUN, when sq_rdy=1 is sampled, the arbiter SHALL capture sq_sqrt into result and go to DONE.
REQ-022 In RUN, when the counter reaches TIMEOUT-1 with sq_rdy=0, the arbiter SHALL load result=0, set the error flag and go to DONE.
REQ-023 If sq_rdy=1 and the timeout occur in the same cycle, sq_rdy SHALL win and no error is raised.
REQ-024 DONE SHALL last one cycle with done[grant_id]=1, err=flag, sq_en=0, update last_id to grant_id, then go to IDLE.
REQ-025 Latency SHALL be 3+k cycles from grant to done, where k is the number of RUN cycles up to and including the sq_rdy sample.
REQ-026 If req[grant_id] drops mid-operation, the operation SHALL still complete and done SHALL still pulse; there is no cancel.
REQ-027 A requester whose req stays high after its done SHALL be re-arbitrated from the next IDLE cycle under normal round-robin priority.
REQ-028 Changes on a_bus after the grant SHALL have no effect on sq_a.

Reset
REQ-029 With rst=0 at a clock edge, the block SHALL force: state=IDLE; done=0; err=0; result=0; grant_id=0; busy=0; sq_en=0; sq_a=0; counter=0; last_id=NREQ-1 (so requester 0 wins first).
REQ-030 Reset SHALL take priority in any state, including mid-RUN, discarding the current operation.
REQ-031 sq_rst SHALL equal 1 while rst=0, so the shared unit is also cleared.

Structure
REQ-032 A shared package sqrt_arb_pkg SHALL hold the state encoding (2-bit: IDLE=0, CLEAR=1, RUN=2, DONE=3) and the parameter defaults.
REQ-033 One sub-module, sqrt_rr_pick, SHALL exist: a combinational round-robin picker taking req and last_id and returning grant_id plus valid.
REQ-034 The squareroot unit SHALL stay outside the block, connected through the sq_* ports.

Verification
REQ-035 Single request: req=0001, a0=0x41800000 (16.0), model rdy after 5 cycles -> done=0001 at grant+8, result=0x40800000, err=0.
REQ-036 Contention: req=1111 held throughout -> grant order 0,1,2,3,0; exactly one done bit per completion; busy low for exactly one cycle between jobs.
REQ-037 Fairness: last_id=1, req=1001 -> requester 3 is granted before requester 0.
REQ-038 Timeout: model never asserts rdy, TIMEOUT=64 -> done and err high together 66 cycles after grant, result=0.
REQ-039 Reset mid-RUN: rst=0 at RUN cycle 3 -> next cycle all outputs at reset values; after release, req=0100 -> requester 2 is served normally.
REQ-040 Request drop and tie: req[1] dropped during RUN -> done[1] still pulses; sq_rdy=1 on the TIMEOUT-1 cycle -> err=0 and sq_sqrt is captured.
